// File: rtl/core_mul_iter_pkg.sv
// Shared definitions for the iterative multiplier: word widths, FSM
// state encoding and the fixed start-to-ready latency.
package core_mul_iter_pkg;

    localparam int MUL_W       = 32;
    localparam int MUL_LATENCY = MUL_W + 2;

    typedef logic [MUL_W-1:0]   word_t;
    typedef logic [2*MUL_W-1:0] dword_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } mul_state_e;

endpackage

// File: rtl/core_mul_fixup.sv
// Final-cycle result shaping for the iterative multiplier: re-applies the
// product sign, adds the optional accumulator, masks to the requested width
// and derives the negative/zero flags from that width.
module core_mul_fixup
    import core_mul_iter_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic [2*W-1:0] prod_i,
    input  logic           signNeg_i,
    input  logic           add_i,
    input  logic           longMul_i,
    input  logic [W-1:0]   cHi_i,
    input  logic [W-1:0]   cLo_i,
    output logic [W-1:0]   qHi_o,
    output logic [W-1:0]   qLo_o,
    output logic           n_o,
    output logic           z_o
);

    logic [2*W-1:0] res;

    // Negate, accumulate and mask in one pass; all arithmetic wraps mod 2^2W.
    always_comb begin
        res = signNeg_i ? (~prod_i + 1'b1) : prod_i;
        if (add_i) begin
            res = res + (longMul_i ? {cHi_i, cLo_i} : {{W{1'b0}}, cLo_i});
        end
        if (!longMul_i) begin
            res[2*W-1:W] = '0;
            n_o = res[W-1];
            z_o = (res[W-1:0] == '0);
        end else begin
            n_o = res[2*W-1];
            z_o = (res == '0);
        end
    end

    assign qHi_o = res[2*W-1:W];
    assign qLo_o = res[W-1:0];

endmodule

// File: rtl/core_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle on operand
// magnitudes, followed by a single fix-up cycle for sign, accumulate and
// result width. Latency from accepted start to ready is fixed at W+2.
module core_mul_iter
    import core_mul_iter_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         flush,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c_hi,
    input  logic [W-1:0] c_lo,
    input  logic         add,
    input  logic         long_mul,
    input  logic         signed_mul,
    output logic [W-1:0] q_hi,
    output logic [W-1:0] q_lo,
    output logic         n,
    output logic         z,
    output logic         ready
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_COUNT = CW'(W - 1);

    mul_state_e     state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mult_q, mult_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  count_q, count_d;
    logic           signNeg_q, signNeg_d;
    logic           add_q, add_d;
    logic           longMul_q, longMul_d;
    logic [W-1:0]   cHi_q, cHi_d;
    logic [W-1:0]   cLo_q, cLo_d;
    logic [W-1:0]   qHi_q, qHi_d;
    logic [W-1:0]   qLo_q, qLo_d;
    logic           n_q, n_d;
    logic           z_q, z_d;

    logic [W-1:0]   aMag, bMag;
    logic [W:0]     iterSum;
    logic [W-1:0]   fixHi, fixLo;
    logic           fixN, fixZ;

    // The most negative operand negates to 2^(W-1), which still fits unsigned.
    assign aMag = (signed_mul && a[W-1]) ? (~a + 1'b1) : a;
    assign bMag = (signed_mul && b[W-1]) ? (~b + 1'b1) : b;

    // Upper half of the partial product plus the multiplicand, keeping the carry.
    assign iterSum = {1'b0, prod_q[2*W-1:W]} + (mult_q[0] ? {1'b0, mcand_q} : '0);

    core_mul_fixup #(.W(W)) u_fixup (
        .prod_i    (prod_q),
        .signNeg_i (signNeg_q),
        .add_i     (add_q),
        .longMul_i (longMul_q),
        .cHi_i     (cHi_q),
        .cLo_i     (cLo_q),
        .qHi_o     (fixHi),
        .qLo_o     (fixLo),
        .n_o       (fixN),
        .z_o       (fixZ)
    );

    // Next-state and datapath update; flush overrides both start and state.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        prod_d    = prod_q;
        count_d   = count_q;
        signNeg_d = signNeg_q;
        add_d     = add_q;
        longMul_d = longMul_q;
        cHi_d     = cHi_q;
        cLo_d     = cLo_q;
        qHi_d     = qHi_q;
        qLo_d     = qLo_q;
        n_d       = n_q;
        z_d       = z_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mcand_d   = aMag;
                        mult_d    = bMag;
                        signNeg_d = signed_mul & (a[W-1] ^ b[W-1]);
                        add_d     = add;
                        longMul_d = long_mul;
                        cHi_d     = c_hi;
                        cLo_d     = c_lo;
                        prod_d    = '0;
                        count_d   = '0;
                        state_d   = ST_ITER;
                    end
                end
                ST_ITER: begin
                    prod_d  = {iterSum, prod_q[W-1:1]};
                    mult_d  = {prod_q[0], mult_q[W-1:1]};
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    qHi_d   = fixHi;
                    qLo_d   = fixLo;
                    n_d     = fixN;
                    z_d     = fixZ;
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mult_q    <= '0;
            prod_q    <= '0;
            count_q   <= '0;
            signNeg_q <= 1'b0;
            add_q     <= 1'b0;
            longMul_q <= 1'b0;
            cHi_q     <= '0;
            cLo_q     <= '0;
            qHi_q     <= '0;
            qLo_q     <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b1;
        end else begin
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            prod_q    <= prod_d;
            count_q   <= count_d;
            signNeg_q <= signNeg_d;
            add_q     <= add_d;
            longMul_q <= longMul_d;
            cHi_q     <= cHi_d;
            cLo_q     <= cLo_d;
            qHi_q     <= qHi_d;
            qLo_q     <= qLo_d;
            n_q       <= n_d;
            z_q       <= z_d;
        end
    end

    assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign q_hi  = qHi_q;
    assign q_lo  = qLo_q;
    assign n     = n_q;
    assign z     = z_q;

endmodule
